pixel_col_readout: RTL

//  Parametrised per-column digital front end for the photon-counting array.
//  - One counter per pixel row accumulates hits while shutter is high.
//  - On shutter fall the counts are snapshotted into shadow registers and the counters clear.
//  - Shadow data is serialised over LANES daisy-chainable lanes while the next frame counts.
//  - Next-generation dig_fe_array column: row count, counter width and lane count are generic.

---
 rtl/pixel_col_readout.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pixel_col_readout.sv
// Per-column photon-counting front end: row counters, snapshot on shutter fall, multi-lane serial readout.
// Optional build macro PARITY_EN appends one even-parity bit per lane after the data bits.
module pixel_col_readout #(
  parameter int ROWS  = 3,
  parameter int CNT_W = 8,
  parameter int LANES = 2
) (
  input  logic             readClk,
  input  logic             reset,
  input  logic             shutter,
  input  logic             sumMode,
  input  logic [ROWS-1:0]  hit,
  input  logic [LANES-1:0] serIn,
  output logic [LANES-1:0] serOut,
  output logic             busy,
  output logic             frameDone,
  output logic             overrun
);

  localparam int RPL      = (ROWS + LANES - 1) / LANES;
  localparam int DATA_LEN = RPL * CNT_W;
`ifdef PARITY_EN
  localparam int SHIFT_LEN = DATA_LEN + 1;
`else
  localparam int SHIFT_LEN = DATA_LEN;
`endif
  localparam int BC_W = (SHIFT_LEN > 2) ? $clog2(SHIFT_LEN) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(SHIFT_LEN - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]            state;
  logic [BC_W-1:0]       bit_cnt;
  logic                  shutter_q;
  logic                  fall;
  logic [ROWS*CNT_W-1:0] cnt_flat;

  assign fall = shutter_q & ~shutter;
  assign busy = (state == SHIFT);

  // Any fall clears the counters; whether the frame is kept or dropped depends on state.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [CNT_W-1:0] cnt;
    logic [1:0]       inc;
    logic [CNT_W:0]   sum;

    if (r % 2 == 1) begin : g_odd
      assign inc = sumMode ? 2'd0 : {1'b0, hit[r]};
    end else if (r + 1 < ROWS) begin : g_pair
      assign inc = {1'b0, hit[r]} + {1'b0, sumMode & hit[r+1]};
    end else begin : g_last
      assign inc = {1'b0, hit[r]};
    end

    assign sum = {1'b0, cnt} + (CNT_W+1)'(inc);

    always_ff @(posedge readClk) begin
      if (reset) begin
        cnt <= '0;
      end else if (fall) begin
        cnt <= '0;
      end else if (shutter) begin
        cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      end
    end

    assign cnt_flat[r*CNT_W +: CNT_W] = cnt;
  end

  // Each lane register doubles as the shadow copy of its rows; slot 0 sits at the MSB end.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DATA_LEN-1:0]  data;
    logic [SHIFT_LEN-1:0] load;
    logic [SHIFT_LEN-1:0] sh;

    for (genvar s = 0; s < RPL; s++) begin : g_slot
      if (s * LANES + l < ROWS) begin : g_row_slot
        assign data[DATA_LEN-1-s*CNT_W -: CNT_W] = cnt_flat[(s*LANES+l)*CNT_W +: CNT_W];
      end else begin : g_pad_slot
        assign data[DATA_LEN-1-s*CNT_W -: CNT_W] = '0;
      end
    end

`ifdef PARITY_EN
    assign load = {data, ^data};
`else
    assign load = data;
`endif

    always_ff @(posedge readClk) begin
      if (reset) begin
        sh <= '0;
      end else if (!busy && fall) begin
        sh <= load;
      end else if (busy) begin
        sh <= {sh[SHIFT_LEN-2:0], serIn[l]};
      end
    end

    assign serOut[l] = busy ? sh[SHIFT_LEN-1] : serIn[l];
  end

  always_ff @(posedge readClk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shutter_q <= 1'b0;
      frameDone <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      shutter_q <= shutter;
      frameDone <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (fall) overrun <= 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state     <= IDLE;
            frameDone <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
